// File: rtl/act_lut_interp_pipe.sv
// rtl/act_lut_interp_pipe.sv - pipelined multi-channel LUT-interpolation / ReLU / identity activation unit
module act_lut_interp_pipe #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4,
    parameter int CH     = 2,
    localparam int IDX_W = DATA_W - FRAC_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_mode,
    input  logic [CH*DATA_W-1:0] in_z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*DATA_W-1:0] out_a,
    input  logic                 lut_we,
    input  logic [IDX_W-1:0]     lut_addr,
    input  logic [DATA_W-1:0]    lut_data
);
    localparam int DEPTH  = 1 << IDX_W;
    localparam int PROD_W = DATA_W + FRAC_W + 2;
    localparam logic [IDX_W-1:0] MAX_POS_IDX = {1'b0, {(IDX_W-1){1'b1}}};

    logic signed [DATA_W-1:0] lut [DEPTH];
    logic                     en;

    logic [IDX_W-1:0]         idx_c   [CH];
    logic [IDX_W-1:0]         idx_n_c [CH];
    logic signed [DATA_W-1:0] base_c  [CH];
    logic signed [DATA_W-1:0] next_c  [CH];

    logic                     v1;
    logic [1:0]               mode1;
    logic signed [DATA_W-1:0] z1    [CH];
    logic signed [DATA_W-1:0] base1 [CH];
    logic signed [DATA_W-1:0] next1 [CH];
    logic [FRAC_W-1:0]        rem1  [CH];

    logic signed [DATA_W:0]   diff_c [CH];
    logic signed [PROD_W-1:0] prod_c [CH];

    logic                     v2;
    logic [1:0]               mode2;
    logic signed [DATA_W-1:0] z2    [CH];
    logic signed [DATA_W-1:0] base2 [CH];
    logic signed [PROD_W-1:0] prod2 [CH];

    logic [CH*DATA_W-1:0]     a_c;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // The largest positive bucket clamps instead of interpolating toward the negative end of the table.
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            idx_c[k]   = in_z[k*DATA_W+FRAC_W +: IDX_W];
            idx_n_c[k] = idx_c[k] + IDX_W'(1);
            base_c[k]  = lut[idx_c[k]];
            next_c[k]  = (idx_c[k] == MAX_POS_IDX) ? base_c[k] : lut[idx_n_c[k]];
        end
    end

    always_comb begin
        for (int k = 0; k < CH; k++) begin
            diff_c[k] = $signed({next1[k][DATA_W-1], next1[k]}) - $signed({base1[k][DATA_W-1], base1[k]});
            prod_c[k] = PROD_W'(diff_c[k]) * PROD_W'($signed({1'b0, rem1[k]}));
        end
    end

    // Interpolated result lies between base and next, so truncation to DATA_W is exact.
    always_comb begin
        a_c = '0;
        for (int k = 0; k < CH; k++) begin
            case (mode2)
                2'd0:    a_c[k*DATA_W +: DATA_W] = base2[k] + DATA_W'(prod2[k] >>> FRAC_W);
                2'd1:    a_c[k*DATA_W +: DATA_W] = z2[k][DATA_W-1] ? '0 : z2[k];
                default: a_c[k*DATA_W +: DATA_W] = z2[k];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                lut[i] <= '0;
            end
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_a     <= '0;
            mode1     <= '0;
            mode2     <= '0;
            for (int k = 0; k < CH; k++) begin
                z1[k]    <= '0;
                base1[k] <= '0;
                next1[k] <= '0;
                rem1[k]  <= '0;
                z2[k]    <= '0;
                base2[k] <= '0;
                prod2[k] <= '0;
            end
        end else begin
            if (lut_we) begin
                lut[lut_addr] <= lut_data;
            end
            if (en) begin
                v1        <= in_valid;
                v2        <= v1;
                out_valid <= v2;
                if (in_valid) begin
                    mode1 <= in_mode;
                    for (int k = 0; k < CH; k++) begin
                        z1[k]    <= in_z[k*DATA_W +: DATA_W];
                        base1[k] <= base_c[k];
                        next1[k] <= next_c[k];
                        rem1[k]  <= in_z[k*DATA_W +: FRAC_W];
                    end
                end
                if (v1) begin
                    mode2 <= mode1;
                    for (int k = 0; k < CH; k++) begin
                        z2[k]    <= z1[k];
                        base2[k] <= base1[k];
                        prod2[k] <= prod_c[k];
                    end
                end
                if (v2) begin
                    out_a <= a_c;
                end
            end
        end
    end

endmodule
